// File: rtl/spi_tx_sequencer.sv
// spi_tx_sequencer: FIFO-buffered feeder for the SPI transmit core, one {dc, byte} entry per core transfer.
// Optional feature macro SPI_TIMEOUT_EN: abandon a byte after TIMEOUT_CYC cycles without valid and raise sticky o_err.
module spi_tx_sequencer #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned GAP_CYCLES  = 4
`ifdef SPI_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 4096
`endif
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [7:0]                  i_prescaler,
    input  logic                        i_wr_en,
    input  logic                        i_wr_dc,
    input  logic [7:0]                  i_wr_data,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(FIFO_DEPTH):0] o_level,
    output logic                        o_ovf,
    input  logic                        i_spi_valid,
    output logic [9:0]                  o_spi_control,
    output logic [7:0]                  o_spi_data,
    output logic                        o_busy,
    output logic                        o_err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

    entry_t        r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          r_full;
    logic          r_empty;
    logic          r_ovf;
    logic          r_valid_q;
    state_t        r_state;
    entry_t        r_entry;
    logic [9:0]    r_ctrl;
    logic [7:0]    r_data;
    logic          r_busy;
    logic          r_err;
    logic [GW-1:0] r_gap_cnt;

    entry_t        w_head;
    logic          w_done;
    logic          w_push;
    logic          w_pop;
    logic [LW-1:0] w_level_nxt;

`ifdef SPI_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_to_cnt;
    logic          w_timeout;

    assign w_timeout = (r_state == S_SEND) & ~w_done & (r_to_cnt == TW'(TIMEOUT_CYC - 1));
`endif

    assign w_head      = r_mem[r_rptr];
    assign w_done      = i_spi_valid & ~r_valid_q;
    assign w_push      = i_wr_en & ~r_full;
    // Chain into the next entry only while the dc mode is unchanged; otherwise a gap follows.
    assign w_pop       = ~r_empty & ((r_state == S_IDLE) |
                         ((r_state == S_SEND) & w_done & (w_head.dc == r_ctrl[1])));
    assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {i_wr_dc, i_wr_data};
        end
    end

    // FIFO pointers and status flags
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LW'(FIFO_DEPTH));
            r_empty <= (w_level_nxt == '0);
            r_ovf   <= i_wr_en & r_full;
        end
    end

    // Sequencer FSM with registered core-side outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_valid_q <= 1'b0;
            r_entry   <= '0;
            r_ctrl    <= '0;
            r_data    <= '0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_gap_cnt <= '0;
`ifdef SPI_TIMEOUT_EN
            r_to_cnt  <= '0;
`endif
        end else begin
            r_valid_q <= i_spi_valid;
            if (w_pop) begin
                r_entry <= w_head;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_data  <= r_entry.data;
                    r_ctrl  <= {i_prescaler, r_entry.dc, 1'b1};
                    r_state <= S_SEND;
`ifdef SPI_TIMEOUT_EN
                    r_to_cnt <= '0;
`endif
                end
                S_SEND: begin
                    if (w_done) begin
                        if (w_pop) begin
                            r_state <= S_LOAD;
                        end else begin
                            r_ctrl[0] <= 1'b0;
                            r_gap_cnt <= '0;
                            r_state   <= S_GAP;
                        end
                    end
`ifdef SPI_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_ctrl[0] <= 1'b0;
                        r_err     <= 1'b1;
                        r_gap_cnt <= '0;
                        r_state   <= S_GAP;
                    end else begin
                        r_to_cnt <= r_to_cnt + TW'(1);
                    end
`endif
                end
                S_GAP: begin
                    if (r_gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_full        = r_full;
    assign o_empty       = r_empty;
    assign o_level       = r_level;
    assign o_ovf         = r_ovf;
    assign o_spi_control = r_ctrl;
    assign o_spi_data    = r_data;
    assign o_busy        = r_busy;
    assign o_err         = r_err;

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// tb_spi_tx_sequencer: directed bench for spi_tx_sequencer with a simple SPI core model pulsing valid.
`timescale 1ns/1ps
module tb_spi_tx_sequencer;

    localparam int unsigned GAP = 4;
    localparam int unsigned TO  = 4096;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] prescaler;
    logic       wr_en;
    logic       wr_dc;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       ovf;
    logic       core_valid;
    logic       man_valid;
    logic       core_auto;
    logic [9:0] spi_control;
    logic [7:0] spi_data;
    logic       busy;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spi_tx_sequencer dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_prescaler   (prescaler),
        .i_wr_en       (wr_en),
        .i_wr_dc       (wr_dc),
        .i_wr_data     (wr_data),
        .o_full        (full),
        .o_empty       (empty),
        .o_level       (level),
        .o_ovf         (ovf),
        .i_spi_valid   (core_valid | man_valid),
        .o_spi_control (spi_control),
        .o_spi_data    (spi_data),
        .o_busy        (busy),
        .o_err         (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic dc, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_dc   = dc;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_en(input int budget, output logic found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (spi_control[0]) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_idle(input int budget, output logic found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Core model: pulse valid for one cycle 20 cycles after a byte is presented
    initial begin : core_model
        core_valid = 1'b0;
        forever begin
            tick();
            if (core_auto && spi_control[0]) begin
                repeat (20) tick();
                if (core_auto && spi_control[0]) begin
                    core_valid = 1'b1;
                    tick();
                    core_valid = 1'b0;
                    tick();
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic found;
        int   cnt;

        rst_n     = 1'b0;
        prescaler = 8'd4;
        wr_en     = 1'b0;
        wr_dc     = 1'b0;
        wr_data   = 8'h00;
        man_valid = 1'b0;
        core_auto = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Reset state
        chk("rst_ctrl",  32'(spi_control), 32'h000);
        chk("rst_data",  32'(spi_data),    32'h00);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_empty", 32'(empty),       32'd1);
        chk("rst_full",  32'(full),        32'd0);
        chk("rst_level", 32'(level),       32'd0);
        chk("rst_ovf",   32'(ovf),         32'd0);
        chk("rst_err",   32'(err),         32'd0);

        // Same-dc burst: enable stays high across both bytes
        core_auto = 1'b1;
        push(1'b0, 8'hAE);
        push(1'b0, 8'hD5);
        chk("lat_en_n2",   32'(spi_control[0]), 32'd0);
        chk("lat_busy_n2", 32'(busy),           32'd1);
        tick();
        chk("lat_en_n3",  32'(spi_control[0]), 32'd1);
        chk("b1_data",    32'(spi_data),       32'hAE);
        chk("b1_ctrl",    32'(spi_control),    32'h011);
        cnt   = 0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!spi_control[0]) cnt++;
            if (spi_data == 8'hD5) begin
                found = 1'b1;
                break;
            end
        end
        chk("b2_seen",  32'(found),       32'd1);
        chk("b2_drops", 32'(cnt),         32'd0);
        chk("b2_ctrl",  32'(spi_control), 32'h011);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!spi_control[0]) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("gap_seen", 32'(found),       32'd1);
        chk("gap_ctrl", 32'(spi_control), 32'h010);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            cnt++;
            tick();
        end
        chk("gap_len", 32'(cnt), GAP);

        // dc change: gap inserted between the two bytes
        push(1'b0, 8'h21);
        push(1'b1, 8'hFF);
        wait_en(10, found);
        chk("dc_b1_seen", 32'(found),       32'd1);
        chk("dc_b1_data", 32'(spi_data),    32'h21);
        chk("dc_b1_ctrl", 32'(spi_control), 32'h011);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!spi_control[0]) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("dc_fall", 32'(found), 32'd1);
        cnt = 0;
        while (!spi_control[0] && cnt < 50) begin
            cnt++;
            tick();
        end
        // GAP_CYCLES in GAP, then one IDLE (pop) and one LOAD cycle before enable returns
        chk("dc_low_len", 32'(cnt),         GAP + 2);
        chk("dc_b2_data", 32'(spi_data),    32'hFF);
        chk("dc_b2_ctrl", 32'(spi_control), 32'h013);
        wait_idle(100, found);
        chk("dc_idle", 32'(found), 32'd1);
`ifndef SPI_TIMEOUT_EN
        chk("err_tied0", 32'(err), 32'd0);
`endif

        // Overflow: fill while the first entry stalls in SEND
        core_auto = 1'b0;
        for (int i = 0; i < 17; i++) begin
            push(1'b0, 8'(8'h40 + i));
        end
        chk("fill_level", 32'(level),          32'd16);
        chk("fill_full",  32'(full),           32'd1);
        chk("fill_data",  32'(spi_data),       32'h40);
        chk("fill_en",    32'(spi_control[0]), 32'd1);
        tick();
        wr_en     = 1'b1;
        wr_dc     = 1'b0;
        wr_data   = 8'hEE;
        man_valid = 1'b1;
        tick();
        wr_en     = 1'b0;
        man_valid = 1'b0;
        chk("ovf_pulse", 32'(ovf),   32'd1);
        chk("ovf_level", 32'(level), 32'd15);
        chk("ovf_full",  32'(full),  32'd0);
        tick();
        chk("ovf_clear", 32'(ovf),      32'd0);
        chk("ovf_next",  32'(spi_data), 32'h41);

        // Asynchronous reset during the third of five entries
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        core_auto = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(1'b0, 8'(8'h50 + i));
        end
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (spi_control[0] && spi_data == 8'h52) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("ar_third_seen", 32'(found), 32'd1);
        repeat (3) tick();
        core_auto = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_ctrl",  32'(spi_control), 32'h000);
        chk("ar_data",  32'(spi_data),    32'h00);
        chk("ar_busy",  32'(busy),        32'd0);
        chk("ar_level", 32'(level),       32'd0);
        chk("ar_empty", 32'(empty),       32'd1);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("ar_post_level", 32'(level), 32'd0);
        chk("ar_post_busy",  32'(busy),  32'd0);

`ifdef SPI_TIMEOUT_EN
        // Timeout: valid never arrives for the first entry
        push(1'b0, 8'h11);
        push(1'b1, 8'h22);
        wait_en(10, found);
        chk("to_start", 32'(found), 32'd1);
        cnt = 0;
        for (int i = 0; i < 5000; i++) begin
            if (!spi_control[0]) break;
            cnt++;
            tick();
        end
        chk("to_len", 32'(cnt),            TO);
        chk("to_err", 32'(err),            32'd1);
        chk("to_en",  32'(spi_control[0]), 32'd0);
        core_auto = 1'b1;
        wait_en(50, found);
        chk("to_next_seen", 32'(found),          32'd1);
        chk("to_next_data", 32'(spi_data),       32'h22);
        chk("to_next_dc",   32'(spi_control[1]), 32'd1);
        wait_idle(100, found);
        chk("to_next_done", 32'(found), 32'd1);
        chk("to_err_stick", 32'(err),   32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
